// File: rtl/soc_ahb3_ext_sram_slave.sv
// AHB3-Lite slave backed by a word-organised SRAM with configurable wait states
// and two-cycle ERROR responses for out-of-range, oversized or misaligned accesses.
module soc_ahb3_ext_sram_slave #(
  parameter int          PLEN        = 32,
  parameter int          XLEN        = 32,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hsel,
  input  logic [PLEN-1:0] haddr,
  input  logic [XLEN-1:0] hwdata,
  input  logic            hwrite,
  input  logic [2:0]      hsize,
  input  logic [2:0]      hburst,
  input  logic [3:0]      hprot,
  input  logic [1:0]      htrans,
  input  logic            hmastlock,
  input  logic            hready,
  output logic [XLEN-1:0] hrdata,
  output logic            hreadyout,
  output logic            hresp
);

  localparam int              AW     = $clog2(DEPTH_WORDS) + 2;
  localparam int              IW     = AW - 2;
  localparam logic [PLEN-1:0] BASE_L = PLEN'(BASE_ADDR);
  localparam logic [2:0]      WS_L   = 3'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_LAST = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  function automatic logic [3:0] byte_en_f(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << lane;
      2'd1:    be = lane[1] ? 4'b1100 : 4'b0011;
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  state_t          state_q;
  logic [2:0]      cnt_q;
  logic [IW-1:0]   idx_q;
  logic [1:0]      lane_q;
  logic [1:0]      size_q;
  logic            wr_q;
  logic            hreadyout_q;
  logic            hresp_q;
  logic [XLEN-1:0] hrdata_q;
  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  logic            accept_s;
  logic            err_s;
  logic            wr_commit_s;
  logic [3:0]      wr_be_s;
  logic [IW-1:0]   addr_idx_s;
  logic [IW-1:0]   rd_idx_s;
  logic [XLEN-1:0] rd_word_s;
  logic            unused_s;

  assign accept_s    = hsel & hready & htrans[1] & hreadyout_q;
  assign addr_idx_s  = haddr[AW-1:2];
  assign wr_commit_s = (state_q == ST_LAST) & wr_q;
  assign wr_be_s     = byte_en_f(size_q, lane_q);
  assign unused_s    = ^{hburst, hprot, hmastlock, htrans[0]};

  assign hrdata    = hrdata_q;
  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;

  always_comb begin
    err_s = 1'b0;
    if (haddr[PLEN-1:AW] != BASE_L[PLEN-1:AW]) begin
      err_s = 1'b1;
    end else if (hsize > 3'd2) begin
      err_s = 1'b1;
    end else if ((hsize == 3'd1) && haddr[0]) begin
      err_s = 1'b1;
    end else if ((hsize == 3'd2) && (haddr[1:0] != 2'b00)) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  // Read word for the transfer entering LAST; a write committing on the same edge is forwarded.
  always_comb begin
    rd_idx_s  = (state_q == ST_WAIT) ? idx_q : addr_idx_s;
    rd_word_s = mem_q[rd_idx_s];
    for (int b = 0; b < 4; b++) begin
      if (wr_commit_s && wr_be_s[b] && (idx_q == rd_idx_s)) begin
        rd_word_s[8*b +: 8] = hwdata[8*b +: 8];
      end else begin
        rd_word_s[8*b +: 8] = rd_word_s[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_commit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_s[b]) begin
          mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      idx_q       <= '0;
      lane_q      <= 2'd0;
      size_q      <= 2'd0;
      wr_q        <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == 3'd0) begin
            state_q     <= ST_LAST;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= wr_q ? '0 : rd_word_s;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        // IDLE, LAST and ERR2 all end a data phase and may accept the next address phase.
        default: begin
          hrdata_q <= '0;
          if (accept_s) begin
            idx_q  <= addr_idx_s;
            lane_q <= haddr[1:0];
            size_q <= hsize[1:0];
            wr_q   <= hwrite & ~err_s;
            cnt_q  <= 3'd0;
            if (err_s) begin
              state_q     <= ST_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state_q     <= ST_WAIT;
              cnt_q       <= WS_L - 3'd1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b0;
            end else begin
              state_q     <= ST_LAST;
              hreadyout_q <= 1'b1;
              hresp_q     <= 1'b0;
              hrdata_q    <= hwrite ? '0 : rd_word_s;
            end
          end else begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_ahb3_ext_sram_slave.sv
// Scoreboard bench: one shared AHB bus drives a WAIT_STATES=1 slave (tgt 1) and a
// WAIT_STATES=0 slave (tgt 0); a monitor checks every completed data phase.
module tb_soc_ahb3_ext_sram_slave;

  typedef struct {
    logic        tgt;
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        resp;
    logic [31:0] rdata;
    string       name;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel0, hsel1;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic [31:0] hrdata0, hrdata1;
  logic        ro0, ro1, resp0, resp1;
  logic        dp_tgt;
  logic        dp_active;
  logic        hready;
  logic [31:0] bus_rdata;
  logic        bus_resp;

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t stim_q[$];
  beat_t exp_q[$];

  always #5 clk = ~clk;

  assign hready    = dp_tgt ? ro1 : ro0;
  assign bus_rdata = dp_tgt ? hrdata1 : hrdata0;
  assign bus_resp  = dp_tgt ? resp1 : resp0;

  soc_ahb3_ext_sram_slave #(.WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .hsel(hsel1), .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans), .hmastlock(hmastlock),
    .hready(hready), .hrdata(hrdata1), .hreadyout(ro1), .hresp(resp1)
  );

  soc_ahb3_ext_sram_slave #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .hsel(hsel0), .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans), .hmastlock(hmastlock),
    .hready(hready), .hrdata(hrdata0), .hreadyout(ro0), .hresp(resp0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic tgt, input logic [1:0] trans, input logic wr, input logic [2:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic err,
                      input logic [31:0] rdata, input string name);
    beat_t b;
    b.tgt   = tgt;
    b.sel   = 1'b1;
    b.trans = trans;
    b.wr    = wr;
    b.size  = size;
    b.addr  = addr;
    b.wdata = wdata;
    b.resp  = err;
    b.waits = err ? 1 : (tgt ? 1 : 0);
    b.rdata = (wr || err) ? 32'h0 : rdata;
    b.name  = name;
    stim_q.push_back(b);
  endtask

  task automatic drive_idle();
    hsel0  = 1'b0;
    hsel1  = 1'b0;
    htrans = 2'd0;
    hwrite = 1'b0;
    hsize  = 3'd2;
    haddr  = 32'h0;
  endtask

  // Cycle-level master: moves address phase to data phase whenever hready was high.
  task automatic run_bus();
    int    cyc      = 0;
    logic  rdy;
    logic  ap_valid = 1'b0;
    beat_t ap;
    while ((stim_q.size() > 0 || ap_valid || dp_active) && cyc < 200) begin
      @(negedge clk);
      rdy = hready;
      @(posedge clk);
      #1;
      cyc++;
      if (rdy) begin
        dp_active = ap_valid;
        if (ap_valid) begin
          dp_tgt = ap.tgt;
          hwdata = ap.wdata;
        end
        if (stim_q.size() > 0) begin
          ap       = stim_q.pop_front();
          hsel0    = ap.sel & ~ap.tgt;
          hsel1    = ap.sel & ap.tgt;
          htrans   = ap.trans;
          hwrite   = ap.wr;
          hsize    = ap.size;
          haddr    = ap.addr;
          ap_valid = ap.sel & ap.trans[1];
          if (ap_valid) exp_q.push_back(ap);
        end else begin
          drive_idle();
          ap_valid = 1'b0;
        end
      end
    end
    if (cyc >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL bus_timeout: got %0d cycles, expected completion under 200", cyc);
    end
    drive_idle();
  endtask

  // Monitor: counts wait cycles of each data phase and compares on completion.
  initial begin
    int    w   = 0;
    logic  bad = 1'b0;
    beat_t e;
    forever begin
      @(negedge clk);
      if (dp_active) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got a data phase, expected none");
        end else if (!hready) begin
          w++;
          if (bus_resp !== exp_q[0].resp || bus_rdata !== 32'h0) bad = 1'b1;
        end else begin
          e = exp_q.pop_front();
          n_tests++;
          if (w != e.waits || bad || bus_resp !== e.resp || bus_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL %s: got waits=%0d resp=%b rdata=%h wait_phase_bad=%b, expected waits=%0d resp=%b rdata=%h",
                     e.name, w, bus_resp, bus_rdata, bad, e.waits, e.resp, e.rdata);
          end
          w   = 0;
          bad = 1'b0;
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    hburst    = 3'd0;
    hprot     = 4'd3;
    hmastlock = 1'b0;
    hwdata    = 32'h0;
    dp_tgt    = 1'b1;
    dp_active = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    check("reset_hreadyout", {31'd0, ro1}, 32'd1);
    check("reset_hresp", {31'd0, resp1}, 32'd0);
    check("reset_hrdata", hrdata1, 32'h0);
    rst = 1'b0;

    // Word write then read, one wait state
    push(1'b1, 2'd2, 1'b1, 3'd2, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, "ws1_word_wr");
    push(1'b1, 2'd2, 1'b0, 3'd2, 32'h8000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, "ws1_word_rd");
    // Byte lanes
    push(1'b1, 2'd2, 1'b1, 3'd0, 32'h8000_0020, 32'h0000_0011, 1'b0, 32'h0, "byte_wr0");
    push(1'b1, 2'd2, 1'b1, 3'd0, 32'h8000_0021, 32'h0000_2200, 1'b0, 32'h0, "byte_wr1");
    push(1'b1, 2'd2, 1'b1, 3'd0, 32'h8000_0022, 32'h0033_0000, 1'b0, 32'h0, "byte_wr2");
    push(1'b1, 2'd2, 1'b1, 3'd0, 32'h8000_0023, 32'h4400_0000, 1'b0, 32'h0, "byte_wr3");
    push(1'b1, 2'd2, 1'b0, 3'd2, 32'h8000_0020, 32'h0, 1'b0, 32'h4433_2211, "byte_rd");
    // Halfword lanes
    push(1'b1, 2'd2, 1'b1, 3'd2, 32'h8000_0030, 32'hAAAA_AAAA, 1'b0, 32'h0, "half_base_wr");
    push(1'b1, 2'd2, 1'b1, 3'd1, 32'h8000_0032, 32'h5555_0000, 1'b0, 32'h0, "half_hi_wr");
    push(1'b1, 2'd2, 1'b1, 3'd1, 32'h8000_0030, 32'h0000_1234, 1'b0, 32'h0, "half_lo_wr");
    push(1'b1, 2'd2, 1'b0, 3'd2, 32'h8000_0030, 32'h0, 1'b0, 32'h5555_1234, "half_rd");
    // Error responses leave memory untouched
    push(1'b1, 2'd2, 1'b1, 3'd2, 32'h8000_0000, 32'h0123_4567, 1'b0, 32'h0, "err_pre_wr");
    push(1'b1, 2'd2, 1'b0, 3'd2, 32'h8000_1000, 32'h0, 1'b1, 32'h0, "err_range_hi");
    push(1'b1, 2'd2, 1'b1, 3'd1, 32'h8000_0001, 32'hFFFF_FFFF, 1'b1, 32'h0, "err_half_misalign");
    push(1'b1, 2'd2, 1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, "err_size3");
    push(1'b1, 2'd2, 1'b1, 3'd2, 32'h8000_0002, 32'hFFFF_FFFF, 1'b1, 32'h0, "err_word_misalign");
    push(1'b1, 2'd2, 1'b0, 3'd2, 32'h7FFF_FFFC, 32'h0, 1'b1, 32'h0, "err_range_lo");
    push(1'b1, 2'd2, 1'b0, 3'd2, 32'h8000_0000, 32'h0, 1'b0, 32'h0123_4567, "err_mem_intact");
    run_bus();

    // IDLE and BUSY with hsel high: no data phase, no write
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      hsel1  = 1'b1;
      htrans = (i == 2) ? 2'd1 : 2'd0;
      hwrite = 1'b1;
      hsize  = 3'd2;
      haddr  = 32'h8000_0010;
      hwdata = 32'h0;
      @(negedge clk);
      check("idle_hreadyout", {31'd0, ro1}, 32'd1);
      check("idle_hresp", {31'd0, resp1}, 32'd0);
    end
    drive_idle();
    push(1'b1, 2'd2, 1'b0, 3'd2, 32'h8000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, "idle_no_write");
    run_bus();

    // Reset during the WAIT cycle of a write aborts it
    @(posedge clk);
    #1;
    dp_tgt = 1'b1;
    hsel1  = 1'b1;
    htrans = 2'd2;
    hwrite = 1'b1;
    hsize  = 3'd2;
    haddr  = 32'h8000_0010;
    @(posedge clk);
    #1;
    drive_idle();
    hwdata = 32'hCAFE_F00D;
    check("rst_in_wait", {31'd0, ro1}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_hreadyout", {31'd0, ro1}, 32'd1);
    check("rst_async_hresp", {31'd0, resp1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push(1'b1, 2'd2, 1'b0, 3'd2, 32'h8000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, "rst_no_commit");
    run_bus();

    // Zero wait states: back-to-back bursts and same-address read after write
    push(1'b0, 2'd2, 1'b1, 3'd2, 32'h8000_0040, 32'h0000_0001, 1'b0, 32'h0, "ws0_wr1");
    push(1'b0, 2'd3, 1'b1, 3'd2, 32'h8000_0044, 32'h0000_0002, 1'b0, 32'h0, "ws0_wr2");
    push(1'b0, 2'd3, 1'b1, 3'd2, 32'h8000_0048, 32'h0000_0003, 1'b0, 32'h0, "ws0_wr3");
    push(1'b0, 2'd3, 1'b1, 3'd2, 32'h8000_004C, 32'h0000_0004, 1'b0, 32'h0, "ws0_wr4");
    push(1'b0, 2'd2, 1'b1, 3'd2, 32'h8000_0050, 32'hA5A5_A5A5, 1'b0, 32'h0, "ws0_fwd_wr");
    push(1'b0, 2'd2, 1'b0, 3'd2, 32'h8000_0050, 32'h0, 1'b0, 32'hA5A5_A5A5, "ws0_fwd_rd");
    push(1'b0, 2'd2, 1'b0, 3'd2, 32'h8000_0040, 32'h0, 1'b0, 32'h0000_0001, "ws0_rd1");
    push(1'b0, 2'd3, 1'b0, 3'd2, 32'h8000_0044, 32'h0, 1'b0, 32'h0000_0002, "ws0_rd2");
    push(1'b0, 2'd3, 1'b0, 3'd2, 32'h8000_0048, 32'h0, 1'b0, 32'h0000_0003, "ws0_rd3");
    push(1'b0, 2'd3, 1'b0, 3'd2, 32'h8000_004C, 32'h0, 1'b0, 32'h0000_0004, "ws0_rd4");
    push(1'b0, 2'd2, 1'b0, 3'd2, 32'h8000_1004, 32'h0, 1'b1, 32'h0, "ws0_err");
    run_bus();

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
